phase_shift_ctrl: RTL and testbench

//  Closes the phi0->phi2 delay loop. Consumes signed phase-error measurements from the

---
 rtl/phase_shift_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_phase_shift_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_shift_ctrl.sv
// rtl/phase_shift_ctrl.sv - phi0->phi2 delay-loop controller driving the DCM_SP variable phase-shift port
//
// Purpose:
//   Takes signed phase-error measurements from the clock-difference stage and
//   steps the DCM_SP phase (PSEN/PSINCDEC/PSDONE) until the error sits inside a
//   deadband, then reports lock. Everything runs on eclk.
//
// Ports:
//   eclk         in   1   emulation clock, all logic on posedge
//   ereset_n     in   1   asynchronous active-low reset
//   enable       in   1   loop enable; low = no new bursts, clears locked
//   diff_valid   in   1   1-cycle strobe, diffticks holds a new measurement
//   diffticks    in   16  signed error; >0 = phi2 early -> increment phase
//   psdone       in   1   DCM_SP PSDONE pulse
//   psen         out  1   DCM_SP PSEN pulse
//   psincdec     out  1   DCM_SP PSINCDEC, 1 = increment
//   phase_pos    out  10  signed accumulated phase steps applied
//   locked       out  1   loop in lock
//   at_limit     out  1   last step blocked by PS_LIMIT (sticky until a step succeeds)
//   timeout_err  out  1   psdone never arrived; sticky until reset
//   busy         out  1   controller not idle

module phase_shift_ctrl #(
    parameter int DEADBAND    = 2,
    parameter int GAIN_SHIFT  = 1,
    parameter int MAX_STEPS   = 8,
    parameter int PS_LIMIT    = 255,
    parameter int LOCK_COUNT  = 4,
    parameter int SETTLE_MEAS = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic               eclk,
    input  logic               ereset_n,
    input  logic               enable,
    input  logic               diff_valid,
    input  logic signed [15:0] diffticks,
    input  logic               psdone,
    output logic               psen,
    output logic               psincdec,
    output logic signed [9:0]  phase_pos,
    output logic               locked,
    output logic               at_limit,
    output logic               timeout_err,
    output logic               busy
);

    localparam int REM_W = $clog2(MAX_STEPS + 1);
    localparam int LCK_W = $clog2(LOCK_COUNT + 2);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int SET_W = $clog2(SETTLE_MEAS + 2);

    localparam logic [15:0]        DEADBAND_W  = 16'(DEADBAND);
    localparam logic [15:0]        MAX_STEPS_W = 16'(MAX_STEPS);
    localparam logic [REM_W-1:0]   REM_MAX     = REM_W'(MAX_STEPS);
    localparam logic [REM_W-1:0]   REM_ONE     = REM_W'(1);
    localparam logic [LCK_W-1:0]   LOCK_MAX    = LCK_W'(LOCK_COUNT);
    localparam logic [TMR_W-1:0]   TIMER_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_MEAS - 1);
    localparam logic signed [9:0]  POS_LIM     = 10'(PS_LIMIT);
    localparam logic signed [9:0]  NEG_LIM     = -POS_LIM;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_WAIT   = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               psen_q, psen_d;
    logic               psincdec_q, psincdec_d;
    logic signed [9:0]  phase_q, phase_d;
    logic               locked_q, locked_d;
    logic               at_limit_q, at_limit_d;
    logic               timeout_q, timeout_d;
    logic [LCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic               dir_q, dir_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [SET_W-1:0]   settle_q, settle_d;

    // Magnitude of the error; -32768 has no positive counterpart, so saturate.
    logic [15:0] abs_d;
    logic [15:0] scaled;
    logic [REM_W-1:0] steps_req;
    logic [LCK_W-1:0] lock_cnt_sat;

    always_comb begin
        if (!diffticks[15]) begin
            abs_d = diffticks;
        end else if (diffticks == 16'sh8000) begin
            abs_d = 16'h7FFF;
        end else begin
            abs_d = 16'(-diffticks);
        end
    end

    // Requested burst length: scaled error, at least one step, never above MAX_STEPS.
    always_comb begin
        scaled = abs_d >> GAIN_SHIFT;
        if (scaled == 16'd0) begin
            steps_req = REM_ONE;
        end else if (scaled > MAX_STEPS_W) begin
            steps_req = REM_MAX;
        end else begin
            steps_req = scaled[REM_W-1:0];
        end
    end

    assign lock_cnt_sat = (lock_cnt_q >= LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        psen_d     = 1'b0;
        psincdec_d = psincdec_q;
        phase_d    = phase_q;
        locked_d   = locked_q;
        at_limit_d = at_limit_q;
        timeout_d  = timeout_q;
        lock_cnt_d = lock_cnt_q;
        rem_d      = rem_q;
        dir_d      = dir_q;
        timer_d    = timer_q;
        settle_d   = settle_q;

        case (state_q)
            S_IDLE: begin
                if (diff_valid && enable && !timeout_q) begin
                    if (abs_d <= DEADBAND_W) begin
                        lock_cnt_d = lock_cnt_sat;
                        if (lock_cnt_sat >= LOCK_MAX) begin
                            locked_d = 1'b1;
                        end
                    end else begin
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                        dir_d      = (diffticks > 16'sd0);
                        rem_d      = steps_req;
                        state_d    = S_STEP;
                    end
                end
            end

            S_STEP: begin
                if (!enable) begin
                    // Loop disabled before this step was issued: end the burst quietly.
                    rem_d    = '0;
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end else if ((dir_q && (phase_q == POS_LIM)) ||
                             (!dir_q && (phase_q == NEG_LIM))) begin
                    at_limit_d = 1'b1;
                    rem_d      = '0;
                    settle_d   = '0;
                    state_d    = S_SETTLE;
                end else begin
                    psen_d     = 1'b1;
                    psincdec_d = dir_q;
                    timer_d    = '0;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                // psdone is checked first so a completion on the last timer cycle still counts.
                if (psdone) begin
                    phase_d    = dir_q ? phase_q + 10'sd1 : phase_q - 10'sd1;
                    at_limit_d = 1'b0;
                    psincdec_d = 1'b0;
                    rem_d      = rem_q - 1'b1;
                    if ((rem_q != REM_ONE) && enable) begin
                        state_d = S_STEP;
                    end else begin
                        settle_d = '0;
                        state_d  = S_SETTLE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d  = 1'b1;
                    locked_d   = 1'b0;
                    psincdec_d = 1'b0;
                    rem_d      = '0;
                    state_d    = S_IDLE;
                end
            end

            S_SETTLE: begin
                // Measurements taken across a step burst are stale; drop a fixed number.
                if (SETTLE_MEAS == 0) begin
                    state_d = S_IDLE;
                end else if (diff_valid) begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!enable) begin
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            state_q    <= S_IDLE;
            psen_q     <= 1'b0;
            psincdec_q <= 1'b0;
            phase_q    <= '0;
            locked_q   <= 1'b0;
            at_limit_q <= 1'b0;
            timeout_q  <= 1'b0;
            lock_cnt_q <= '0;
            rem_q      <= '0;
            dir_q      <= 1'b0;
            timer_q    <= '0;
            settle_q   <= '0;
        end else begin
            state_q    <= state_d;
            psen_q     <= psen_d;
            psincdec_q <= psincdec_d;
            phase_q    <= phase_d;
            locked_q   <= locked_d;
            at_limit_q <= at_limit_d;
            timeout_q  <= timeout_d;
            lock_cnt_q <= lock_cnt_d;
            rem_q      <= rem_d;
            dir_q      <= dir_d;
            timer_q    <= timer_d;
            settle_q   <= settle_d;
        end
    end

    assign psen        = psen_q;
    assign psincdec    = psincdec_q;
    assign phase_pos   = phase_q;
    assign locked      = locked_q;
    assign at_limit    = at_limit_q;
    assign timeout_err = timeout_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_phase_shift_ctrl.sv
// tb/tb_phase_shift_ctrl.sv - scoreboard bench for phase_shift_ctrl
`timescale 1ns/1ps

module tb_phase_shift_ctrl;

    logic               eclk = 1'b0;
    logic               ereset_n = 1'b0;
    logic               enable = 1'b1;
    logic               diff_valid = 1'b0;
    logic signed [15:0] diffticks = 16'sd0;
    logic               psdone = 1'b0;
    logic               psen;
    logic               psincdec;
    logic signed [9:0]  phase_pos;
    logic               locked;
    logic               at_limit;
    logic               timeout_err;
    logic               busy;

    int n_checks = 0;
    int n_errors = 0;

    // Expected {psincdec, phase_pos before the step} for every psen pulse.
    logic [10:0]        exp_q[$];
    logic [10:0]        mon_e;
    logic               suppress = 1'b0;
    logic signed [9:0]  model_pos = 10'sd0;

    phase_shift_ctrl dut (
        .eclk        (eclk),
        .ereset_n    (ereset_n),
        .enable      (enable),
        .diff_valid  (diff_valid),
        .diffticks   (diffticks),
        .psdone      (psdone),
        .psen        (psen),
        .psincdec    (psincdec),
        .phase_pos   (phase_pos),
        .locked      (locked),
        .at_limit    (at_limit),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 eclk = ~eclk;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: every psen pulse must match the head of the scoreboard.
    always @(negedge eclk) begin
        if (ereset_n && psen === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL psen_unexpected: got psen pulse at phase_pos=%0d, expected none", phase_pos);
            end else begin
                mon_e = exp_q.pop_front();
                if ({psincdec, phase_pos} !== mon_e) begin
                    n_errors++;
                    $display("FAIL psen_pulse: got dir=%0b pos=%0d, expected dir=%0b pos=%0d",
                             psincdec, phase_pos, mon_e[10], $signed(mon_e[9:0]));
                end
            end
        end
    end

    // DCM model: psdone 5 cycles after each psen unless suppressed.
    initial begin
        forever begin
            @(negedge eclk);
            if (psen === 1'b1 && !suppress) begin
                repeat (5) @(negedge eclk);
                psdone = 1'b1;
                @(negedge eclk);
                psdone = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    task automatic strobe(input logic signed [15:0] d);
        @(negedge eclk);
        diffticks  = d;
        diff_valid = 1'b1;
        @(negedge eclk);
        diff_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge eclk);
        ereset_n = 1'b0;
        exp_q.delete();
        model_pos = 10'sd0;
        repeat (2) @(negedge eclk);
        ereset_n = 1'b1;
        @(negedge eclk);
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            @(negedge eclk);
            c++;
        end
        chk({name, "_drain"}, exp_q.size(), 0);
        repeat (10) @(negedge eclk);
    endtask

    task automatic settle(input string name);
        chk({name, "_busy_settle"}, int'(busy), 1);
        strobe(16'sd50);
        chk({name, "_busy_settle1"}, int'(busy), 1);
        strobe(16'sd50);
        chk({name, "_busy_idle"}, int'(busy), 0);
    endtask

    task automatic burst(input logic signed [15:0] d, input int n, input logic dir, input string name);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({dir, model_pos});
            model_pos = dir ? model_pos + 10'sd1 : model_pos - 10'sd1;
        end
        strobe(d);
        wait_drain(name);
        settle(name);
        chk({name, "_phase"}, int'(phase_pos), int'(model_pos));
    endtask

    initial begin
        int c;
        int k;

        // Reset state, before any clock edge.
        #1;
        chk("rst_psen", int'(psen), 0);
        chk("rst_psincdec", int'(psincdec), 0);
        chk("rst_phase", int'(phase_pos), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_at_limit", int'(at_limit), 0);
        chk("rst_timeout", int'(timeout_err), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge eclk);
        ereset_n = 1'b1;
        @(negedge eclk);

        // 1: +6 -> 3 increments.
        burst(16'sd6, 3, 1'b1, "t1");

        // 2: -40 -> clamp 8 decrements; -32768 -> clamp 8, no overflow.
        do_reset();
        burst(-16'sd40, 8, 1'b0, "t2a");
        chk("t2a_phase_abs", int'(phase_pos), -8);
        burst(16'sh8000, 8, 1'b0, "t2b");
        chk("t2b_phase_abs", int'(phase_pos), -16);

        // 3: deadband strobes build lock; +9 breaks it.
        do_reset();
        strobe(16'sd1);
        strobe(-16'sd2);
        strobe(16'sd0);
        chk("t3_locked_3rd", int'(locked), 0);
        strobe(16'sd2);
        chk("t3_locked_4th", int'(locked), 1);
        chk("t3_busy", int'(busy), 0);
        @(negedge eclk);
        enable = 1'b0;
        @(negedge eclk);
        chk("t3_locked_disabled", int'(locked), 0);
        strobe(16'sd6);
        chk("t3_busy_disabled", int'(busy), 0);
        enable = 1'b1;
        strobe(16'sd0);
        chk("t3_relock", int'(locked), 1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b1, model_pos});
            model_pos = model_pos + 10'sd1;
        end
        strobe(16'sd9);
        chk("t3_unlock", int'(locked), 0);
        wait_drain("t3b");
        settle("t3b");
        chk("t3b_phase", int'(phase_pos), 4);

        // 4: walk to +254, then one step to the limit.
        do_reset();
        for (int i = 0; i < 31; i++) begin
            burst(16'sd16, 8, 1'b1, "t4_pre");
        end
        burst(16'sd12, 6, 1'b1, "t4_pre6");
        chk("t4_phase254", int'(phase_pos), 254);
        burst(16'sd20, 1, 1'b1, "t4_limit");
        chk("t4_phase255", int'(phase_pos), 255);
        chk("t4_at_limit", int'(at_limit), 1);
        burst(16'sd20, 0, 1'b1, "t4_blocked");
        chk("t4_at_limit_hold", int'(at_limit), 1);
        burst(-16'sd4, 2, 1'b0, "t4_down");
        chk("t4_at_limit_clr", int'(at_limit), 0);
        chk("t4_phase253", int'(phase_pos), 253);

        // 5: psdone never arrives -> timeout after exactly 1023 cycles.
        do_reset();
        suppress = 1'b1;
        exp_q.push_back({1'b1, 10'sd0});
        strobe(16'sd6);
        c = 0;
        while (psen !== 1'b1 && c < 20) begin
            @(negedge eclk);
            c++;
        end
        chk("t5_psen_seen", int'(psen), 1);
        k = 0;
        while (timeout_err !== 1'b1 && k < 1100) begin
            @(negedge eclk);
            k++;
        end
        chk("t5_timeout_cycles", k, 1023);
        chk("t5_timeout_err", int'(timeout_err), 1);
        chk("t5_busy", int'(busy), 0);
        chk("t5_phase", int'(phase_pos), 0);
        chk("t5_locked", int'(locked), 0);
        strobe(16'sd6);
        repeat (5) @(negedge eclk);
        chk("t5_frozen_busy", int'(busy), 0);
        chk("t5_frozen_err", int'(timeout_err), 1);
        suppress = 1'b0;
        do_reset();
        chk("t5_err_cleared", int'(timeout_err), 0);

        // 6: async reset in the middle of a WAIT.
        burst(16'sd6, 3, 1'b1, "t6_pre");
        exp_q.push_back({1'b1, 10'sd3});
        strobe(16'sd6);
        c = 0;
        while (exp_q.size() != 0 && c < 20) begin
            @(negedge eclk);
            c++;
        end
        chk("t6_psen_seen", exp_q.size(), 0);
        @(posedge eclk);
        #2;
        chk("t6_pre_psincdec", int'(psincdec), 1);
        chk("t6_pre_busy", int'(busy), 1);
        ereset_n = 1'b0;
        #1;
        chk("t6_async_busy", int'(busy), 0);
        chk("t6_async_phase", int'(phase_pos), 0);
        chk("t6_async_psincdec", int'(psincdec), 0);
        chk("t6_async_psen", int'(psen), 0);
        chk("t6_async_at_limit", int'(at_limit), 0);
        chk("t6_async_locked", int'(locked), 0);
        chk("t6_async_timeout", int'(timeout_err), 0);
        exp_q.delete();
        repeat (3) @(negedge eclk);
        ereset_n = 1'b1;
        repeat (10) @(negedge eclk);
        chk("t6_stray_psdone_phase", int'(phase_pos), 0);
        chk("t6_idle", int'(busy), 0);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
